// File: rtl/march_elem_sequencer_pkg.sv
// ============================================================================
//  Module : march_elem_sequencer_pkg
//  Brief  : Shared constants and helpers for the march element sequencer
//           (op-count / counter-size defaults and instruction-register
//           field positions).
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package march_elem_sequencer_pkg;

  // Maximum number of operations in one march element.
  localparam int MARCH_MAX_OPS      = 4;
  // Width of the per-element op cycle counter.
  localparam int CYCLE_COUNTER_SIZE = 2;

  // Instruction-register field widths.
  localparam int IR_BFW_OP  = 4;
  localparam int IR_BFW_POL = MARCH_MAX_OPS;
  localparam int IR_BFW_NO  = CYCLE_COUNTER_SIZE;

  // Instruction-register field base positions (ops, then polarities, then no).
  localparam int IR_BFP_OP  = 0;
  localparam int IR_BFP_POL = IR_BFP_OP + MARCH_MAX_OPS * IR_BFW_OP;
  localparam int IR_BFP_NO  = IR_BFP_POL + IR_BFW_POL;

  // Saturate a requested last-op index to the last slot that exists.
  function automatic int clamp_no(input int no, input int max_ops);
    return (no > max_ops - 1) ? (max_ops - 1) : no;
  endfunction

endpackage

`default_nettype wire

// File: rtl/march_elem_sequencer_wrap_counter.sv
// ============================================================================
//  Module : march_elem_sequencer_wrap_counter
//  Brief  : CS-bit op cycle counter with synchronous reset, synchronous
//           clear, hold, and wrap to zero after reaching a programmable limit.
//           hit flags cnt == limit.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module march_elem_sequencer_wrap_counter #(
  parameter int CS = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          en,
  input  logic [CS-1:0] limit,
  output logic [CS-1:0] cnt,
  output logic          hit
);

  // Hit is purely the comparator against the current limit.
  always_comb begin
    hit = (cnt == limit);
  end

  // Count step: clear wins over advance; advancing at the limit wraps to 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      if (hit) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + CS'(1);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/march_elem_sequencer.sv
// ============================================================================
//  Module : march_elem_sequencer
//  Brief  : Cycle controller for one march element. Shadows the element's
//           op/polarity/op-count fields on start, steps a wrapping op counter
//           through ops 0..no, requests address increments after the last op
//           and pulses elem_done_out when the last op runs at the last
//           address.
//  Config : define MARCH_SEQ_STALL_EN to let stall_in freeze the element;
//           otherwise stall_in is ignored.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module march_elem_sequencer
  import march_elem_sequencer_pkg::*;
#(
  parameter int MAX_OPS = MARCH_MAX_OPS,
  parameter int OP_W    = IR_BFW_OP,
  parameter int CS      = CYCLE_COUNTER_SIZE
) (
  input  logic                    clk,
  input  logic                    r_in,
  input  logic                    start_in,
  input  logic                    stall_in,
  input  logic [CS-1:0]           no_in,
  input  logic [MAX_OPS*OP_W-1:0] op_in,
  input  logic [MAX_OPS-1:0]      pol_in,
  input  logic                    addr_last_in,
  output logic [OP_W-1:0]         op_out,
  output logic                    pol_out,
  output logic                    op_valid_out,
  output logic                    last_op_out,
  output logic                    addr_inc_out,
  output logic                    elem_done_out,
  output logic                    busy_out
);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [MAX_OPS*OP_W-1:0] op_q;
  logic [MAX_OPS-1:0]      pol_q;
  logic [CS-1:0]           no_q;
  logic [CS-1:0]           cnt;
  logic                    hit;
  logic                    run;
  logic                    latch;
  logic                    stall_eff;

`ifdef MARCH_SEQ_STALL_EN
  assign stall_eff = stall_in;
`else
  // stall_in stays on the port for a uniform interface but has no effect.
  logic stall_unused;
  assign stall_unused = stall_in;
  assign stall_eff    = 1'b0;
`endif

  assign run = (state == S_RUN);

  // State register; reset aborts any element without a done pulse.
  always_ff @(posedge clk) begin
    if (r_in) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state: start only honoured in IDLE, leave RUN on the done edge.
  always_comb begin
    state_nxt = state;
    latch     = 1'b0;
    case (state)
      S_IDLE: begin
        if (start_in) begin
          state_nxt = S_RUN;
          latch     = 1'b1;
        end
      end
      S_RUN: begin
        if (elem_done_out) begin
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Shadow the element fields at start; a too-large op count saturates.
  always_ff @(posedge clk) begin
    if (r_in) begin
      op_q  <= '0;
      pol_q <= '0;
      no_q  <= '0;
    end else if (latch) begin
      op_q  <= op_in;
      pol_q <= pol_in;
      no_q  <= CS'(clamp_no(int'(no_in), MAX_OPS));
    end
  end

  march_elem_sequencer_wrap_counter #(
    .CS (CS)
  ) u_wrap_counter (
    .clk   (clk),
    .rst   (r_in),
    .clr   (latch),
    .en    (run & ~stall_eff),
    .limit (no_q),
    .cnt   (cnt),
    .hit   (hit)
  );

  // Outputs: shadow[cnt] plus handshake flags, all zero outside RUN.
  always_comb begin
    op_out        = '0;
    pol_out       = 1'b0;
    op_valid_out  = 1'b0;
    last_op_out   = 1'b0;
    addr_inc_out  = 1'b0;
    elem_done_out = 1'b0;
    busy_out      = run;
    if (run) begin
      op_valid_out = 1'b1;
      for (int k = 0; k < MAX_OPS; k++) begin
        if (cnt == CS'(k)) begin
          op_out  = op_q[k*OP_W +: OP_W];
          pol_out = pol_q[k];
        end
      end
      last_op_out   = hit;
      addr_inc_out  = hit & ~stall_eff;
      elem_done_out = hit & ~stall_eff & addr_last_in;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_march_elem_sequencer.sv
// ============================================================================
//  Module : tb_march_elem_sequencer
//  Brief  : Self-checking bench for march_elem_sequencer: directed element
//           scenarios followed by randomized stimulus, every cycle compared
//           against a behavioural element model.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_march_elem_sequencer;

  localparam int MAX_OPS = 4;
  localparam int OP_W    = 4;
  localparam int CS      = 3;

`ifdef MARCH_SEQ_STALL_EN
  localparam bit STALL_MODEL = 1'b1;
`else
  localparam bit STALL_MODEL = 1'b0;
`endif

  logic                    clk = 1'b0;
  logic                    r_in = 1'b0;
  logic                    start_in = 1'b0;
  logic                    stall_in = 1'b0;
  logic [CS-1:0]           no_in = '0;
  logic [MAX_OPS*OP_W-1:0] op_in = '0;
  logic [MAX_OPS-1:0]      pol_in = '0;
  logic                    addr_last_in = 1'b0;
  logic [OP_W-1:0]         op_out;
  logic                    pol_out;
  logic                    op_valid_out;
  logic                    last_op_out;
  logic                    addr_inc_out;
  logic                    elem_done_out;
  logic                    busy_out;

  march_elem_sequencer #(
    .MAX_OPS (MAX_OPS),
    .OP_W    (OP_W),
    .CS      (CS)
  ) dut (
    .clk           (clk),
    .r_in          (r_in),
    .start_in      (start_in),
    .stall_in      (stall_in),
    .no_in         (no_in),
    .op_in         (op_in),
    .pol_in        (pol_in),
    .addr_last_in  (addr_last_in),
    .op_out        (op_out),
    .pol_out       (pol_out),
    .op_valid_out  (op_valid_out),
    .last_op_out   (last_op_out),
    .addr_inc_out  (addr_inc_out),
    .elem_done_out (elem_done_out),
    .busy_out      (busy_out)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Element model: one running flag, the op position inside the element and
  // the fields captured at start.
  bit       m_busy = 1'b0;
  int       m_idx  = 0;
  int       m_no   = 0;
  bit [3:0] m_ops [MAX_OPS];
  bit       m_pols[MAX_OPS];

  // Outputs seen in the most recent step, for directed spot checks.
  logic [OP_W-1:0] obs_op;
  logic obs_pol, obs_valid, obs_last, obs_inc, obs_done, obs_busy;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs, compare against the model, advance model.
  task automatic step(input logic rst_v, input logic start_v, input logic stall_v,
                      input logic al_v, input logic [CS-1:0] no_v,
                      input logic [15:0] op_v, input logic [3:0] pol_v);
    bit       s_eff;
    bit [3:0] e_op;
    bit       e_pol, e_valid, e_last, e_inc, e_done;
    r_in         = rst_v;
    start_in     = start_v;
    stall_in     = stall_v;
    addr_last_in = al_v;
    no_in        = no_v;
    op_in        = op_v;
    pol_in       = pol_v;
    #1;
    s_eff   = STALL_MODEL ? stall_v : 1'b0;
    e_op    = m_busy ? m_ops[m_idx] : 4'h0;
    e_pol   = m_busy ? m_pols[m_idx] : 1'b0;
    e_valid = m_busy;
    e_last  = m_busy && (m_idx == m_no);
    e_inc   = e_last && !s_eff;
    e_done  = e_inc && al_v;
    check("op_out",        32'(op_out),  32'(e_op));
    check("pol_out",       32'(pol_out), 32'(e_pol));
    check("op_valid_out",  32'(op_valid_out), 32'(e_valid));
    check("last_op_out",   32'(last_op_out),  32'(e_last));
    check("addr_inc_out",  32'(addr_inc_out), 32'(e_inc));
    check("elem_done_out", 32'(elem_done_out), 32'(e_done));
    check("busy_out",      32'(busy_out), 32'(m_busy));
    obs_op = op_out; obs_pol = pol_out; obs_valid = op_valid_out;
    obs_last = last_op_out; obs_inc = addr_inc_out; obs_done = elem_done_out;
    obs_busy = busy_out;
    @(posedge clk);
    if (rst_v) begin
      m_busy = 1'b0;
      m_idx  = 0;
    end else if (!m_busy) begin
      if (start_v) begin
        m_busy = 1'b1;
        m_idx  = 0;
        m_no   = (int'(no_v) > MAX_OPS - 1) ? MAX_OPS - 1 : int'(no_v);
        for (int k = 0; k < MAX_OPS; k++) begin
          m_ops[k]  = op_v[k*4 +: 4];
          m_pols[k] = pol_v[k];
        end
      end
    end else if (e_done) begin
      m_busy = 1'b0;
      m_idx  = 0;
    end else if (!s_eff) begin
      m_idx = (m_idx == m_no) ? 0 : m_idx + 1;
    end
    @(negedge clk);
  endtask

  // Idle cycle with everything low.
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0, '0, 16'h0, 4'h0);
  endtask

  task automatic do_reset();
    step(1'b1, 1'b0, 1'b0, 1'b0, '0, 16'h0, 4'h0);
  endtask

  initial begin
    @(negedge clk);

    // Reset state: outputs zero the cycle after reset.
    do_reset();
    do_reset();
    idle(1);
    check("reset_busy",  32'(obs_busy), 32'd0);
    check("reset_valid", 32'(obs_valid), 32'd0);
    check("reset_op",    32'(obs_op), 32'd0);

    // Basic pass then completion on the second pass; start held at T+8.
    step(1'b0, 1'b1, 1'b0, 1'b0, 3'd3, 16'h4321, 4'b1010);          // T
    step(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 16'hFFFF, 4'hF);              // T+1
    check("t1_op0", 32'(obs_op), 32'h1);
    check("t1_pol0", 32'(obs_pol), 32'h0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0, 4'h0);                 // T+2
    check("t1_op1", 32'(obs_op), 32'h2);
    check("t1_pol1", 32'(obs_pol), 32'h1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0, 4'h0);                 // T+3
    step(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0, 4'h0);                 // T+4
    check("t1_op3", 32'(obs_op), 32'h4);
    check("t1_inc", 32'(obs_inc), 32'h1);
    for (int i = 5; i <= 7; i++) step(1'b0, 1'b0, 1'b0, 1'b1, '0, 16'h0, 4'h0);
    step(1'b0, 1'b1, 1'b0, 1'b1, 3'd1, 16'h9999, 4'h0);              // T+8
    check("t2_done", 32'(obs_done), 32'h1);
    step(1'b0, 1'b0, 1'b0, 1'b0, '0, 16'h0, 4'h0);                   // T+9
    check("t2_idle", 32'(obs_busy), 32'h0);
    idle(1);

    // Single-op element.
    step(1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 16'hABC7, 4'b0001);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 1'b0, 1'b0, '0, 16'h0, 4'h0);
      check("t3_op", 32'(obs_op), 32'h7);
      check("t3_inc", 32'(obs_inc), 32'h1);
    end
    step(1'b0, 1'b0, 1'b0, 1'b1, '0, 16'h0, 4'h0);
    idle(1);

    // Clamp: no_in=6 behaves as 3.
    step(1'b0, 1'b1, 1'b0, 1'b0, 3'd6, 16'h8765, 4'b0110);
    for (int i = 1; i <= 5; i++) begin
      step(1'b0, 1'b0, 1'b0, 1'b0, '0, 16'h0, 4'h0);
      if (i == 4) check("t4_last", 32'(obs_last), 32'h1);
    end
    check("t4_wrap", 32'(obs_op), 32'h5);
    do_reset();

    // Stall two cycles while op index 2 is presented.
    step(1'b0, 1'b1, 1'b0, 1'b0, 3'd3, 16'h4321, 4'b1010);
    step(1'b0, 1'b0, 1'b0, 1'b0, '0, 16'h0, 4'h0);
    step(1'b0, 1'b0, 1'b0, 1'b0, '0, 16'h0, 4'h0);
    step(1'b0, 1'b0, 1'b1, 1'b0, '0, 16'h0, 4'h0);
    step(1'b0, 1'b0, 1'b1, 1'b0, '0, 16'h0, 4'h0);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 1'b0, 1'b0, '0, 16'h0, 4'h0);
    do_reset();

    // Reset mid-element, then restart.
    step(1'b0, 1'b1, 1'b0, 1'b1, 3'd1, 16'h00BA, 4'b0011);           // T
    step(1'b0, 1'b0, 1'b0, 1'b1, '0, 16'h0, 4'h0);                    // T+1
    step(1'b1, 1'b0, 1'b0, 1'b1, '0, 16'h0, 4'h0);                    // T+2
    step(1'b0, 1'b0, 1'b0, 1'b1, '0, 16'h0, 4'h0);                    // T+3
    check("t6_busy", 32'(obs_busy), 32'h0);
    check("t6_done", 32'(obs_done), 32'h0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 3'd1, 16'h00C4, 4'b0000);           // T+4
    step(1'b0, 1'b0, 1'b0, 1'b0, '0, 16'h0, 4'h0);                    // T+5
    check("t6_op0", 32'(obs_op), 32'h4);
    do_reset();

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 99) == 0),
           ($urandom_range(0, 2) == 0),
           ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 3) == 0),
           CS'($urandom_range(0, 7)),
           16'($urandom),
           4'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
